// File: rtl/hamming_ctrl_pkg.sv
// Shared encodings for the Hamming shift-register command sequencer:
// host op codes, sequencer states and register mode pins.
package hamming_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_SWAP_R = 2'b10,
        OP_SWAP_L = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_SISO_R = 2'b00;
    localparam logic [1:0] MODE_SISO_L = 2'b01;
    localparam logic [1:0] MODE_PISO   = 2'b10;
    localparam logic [1:0] MODE_PIPO   = 2'b11;

endpackage

// File: rtl/hamming_fault_counter.sv
// Saturating corrected-fault counter with synchronous clear and a level IRQ
// once the count reaches IRQ_THRESH.
module hamming_fault_counter #(
    parameter int CNT_W      = 8,
    parameter int IRQ_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             irq
);

    // Clear dominates a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    assign irq = (32'(count) >= 32'(IRQ_THRESH));

endmodule

// File: rtl/hamming_reg_ctrl.sv
// Command sequencer for the Hamming-protected shift register: WRITE, READ and
// serial swaps. Define HAMMING_CTRL_FAULT_CNT_EN to include the fault counter/IRQ.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// cmd_op/cmd_data are sampled only on that edge and may change freely afterwards.
// rsp_valid is a one-cycle strobe with no backpressure; rsp_data holds until the
// next strobe.
module hamming_reg_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int IRQ_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             reg_enable,
    output logic             reg_load,
    output logic [1:0]       reg_mode,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out,
    input  logic             reg_fault,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] fault_count,
    output logic             fault_irq,
    output logic [2:0]       state_dbg
);

    import hamming_ctrl_pkg::*;

    localparam int KW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_WRITE = ST_WRITE;
    localparam logic [2:0] S_READ  = ST_READ;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_RESP  = ST_RESP;

    logic [2:0]       state_q;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] rsp_q;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    bit_idx;
    logic             last_k;
    logic             accept;

    assign accept  = cmd_valid && cmd_ready;
    assign last_k  = (k_q == KW'(WIDTH - 1));
    // SWAP_L walks the word from the MSB so the left shift lands it in order.
    assign bit_idx = (op_q == OP_SWAP_L) ? (KW'(WIDTH - 1) - k_q) : k_q;

    always_comb begin
        cap_next          = cap_q;
        cap_next[bit_idx] = reg_serial_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_WRITE;
            data_q  <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            k_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op_e'(cmd_op);
                        data_q <= cmd_data;
                        k_q    <= '0;
                        case (op_e'(cmd_op))
                            OP_WRITE: state_q <= S_WRITE;
                            OP_READ:  state_q <= S_READ;
                            default:  state_q <= S_SHIFT;
                        endcase
                    end
                end
                S_WRITE: begin
                    rsp_q   <= data_q;
                    state_q <= S_RESP;
                end
                S_READ: begin
                    rsp_q   <= reg_parallel_out;
                    state_q <= S_RESP;
                end
                S_SHIFT: begin
                    // Old contents collect in cap_q so rsp_data stays stable until RESP.
                    cap_q <= cap_next;
                    k_q   <= k_q + KW'(1);
                    if (last_k) begin
                        rsp_q   <= cap_next;
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register pins are zero whenever enable is low so correction sees a quiet bus.
    always_comb begin
        reg_enable      = 1'b0;
        reg_mode        = MODE_SISO_R;
        reg_load        = 1'b0;
        reg_serial_in   = 1'b0;
        reg_parallel_in = '0;
        case (state_q)
            S_WRITE: begin
                reg_enable      = 1'b1;
                reg_mode        = MODE_PIPO;
                reg_load        = 1'b1;
                reg_parallel_in = data_q;
            end
            S_SHIFT: begin
                reg_enable    = 1'b1;
                reg_mode      = (op_q == OP_SWAP_L) ? MODE_SISO_L : MODE_SISO_R;
                reg_serial_in = data_q[bit_idx];
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_q;
    assign state_dbg = state_q;

`ifdef HAMMING_CTRL_FAULT_CNT_EN
    hamming_fault_counter #(
        .CNT_W      (CNT_W),
        .IRQ_THRESH (IRQ_THRESH)
    ) u_fault_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (!reg_enable && reg_fault),
        .clr   (fault_clr),
        .count (fault_count),
        .irq   (fault_irq)
    );
`else
    localparam int unused_irq_thresh = IRQ_THRESH;
    logic unused_fault_inputs;
    assign unused_fault_inputs = ^{fault_clr, reg_fault};
    assign fault_count = '0;
    assign fault_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_reg_ctrl.sv
// Bench for hamming_reg_ctrl: behavioural shift-register model, per-cycle pin
// schedule expanded from accepted commands, directed checks plus random traffic.
module tb_hamming_reg_ctrl;

  localparam int W   = 8;
  localparam int CW  = 8;
  localparam int THR = 16;
`ifdef HAMMING_CTRL_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic         ready;
    logic         en;
    logic         load;
    logic         si;
    logic         rv;
    logic [1:0]   mode;
    logic [W-1:0] pin;
    logic [W-1:0] rsp;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic started = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (rst) started <= 1'b1;

  // ---------------- DUT signals ----------------
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         reg_enable, reg_load, reg_serial_in, reg_serial_out, reg_fault;
  logic [1:0]   reg_mode;
  logic [W-1:0] reg_parallel_in, reg_parallel_out;
  logic         fault_clr;
  logic [CW-1:0] fault_count;
  logic         fault_irq;
  logic [2:0]   state_dbg;

  logic noise_on = 1'b0, noise_fault = 1'b0, noise_clr = 1'b0;
  logic dir_fault = 1'b0, dir_clr = 1'b0;
  assign reg_fault = noise_fault | dir_fault;
  assign fault_clr = noise_clr | dir_clr;

  hamming_reg_ctrl #(.WIDTH(W), .CNT_W(CW), .IRQ_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
    .reg_serial_in(reg_serial_in), .reg_parallel_in(reg_parallel_in),
    .reg_serial_out(reg_serial_out), .reg_parallel_out(reg_parallel_out),
    .reg_fault(reg_fault), .fault_clr(fault_clr), .fault_count(fault_count),
    .fault_irq(fault_irq), .state_dbg(state_dbg)
  );

  // Narrow-counter instance, always idle, used for saturation at 3.
  logic         cmd_ready2, rsp_valid2, reg_enable2, reg_load2, reg_serial_in2, fault_irq2;
  logic [W-1:0] rsp_data2, reg_parallel_in2;
  logic [1:0]   reg_mode2, fault_count2;
  logic [2:0]   state_dbg2;

  hamming_reg_ctrl #(.WIDTH(W), .CNT_W(2), .IRQ_THRESH(2)) dut_w2 (
    .clk(clk), .rst(rst), .cmd_valid(1'b0), .cmd_ready(cmd_ready2),
    .cmd_op(2'b00), .cmd_data('0), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .reg_enable(reg_enable2), .reg_load(reg_load2), .reg_mode(reg_mode2),
    .reg_serial_in(reg_serial_in2), .reg_parallel_in(reg_parallel_in2),
    .reg_serial_out(1'b0), .reg_parallel_out('0),
    .reg_fault(reg_fault), .fault_clr(fault_clr), .fault_count(fault_count2),
    .fault_irq(fault_irq2), .state_dbg(state_dbg2)
  );

  // ---------------- shift-register model ----------------
  logic [W-1:0] r_q = '0;
  always @(posedge clk) begin
    if (reg_enable) begin
      if (reg_mode == 2'b11 && reg_load) r_q <= reg_parallel_in;
      else if (reg_mode == 2'b00) r_q <= {reg_serial_in, r_q[W-1:1]};
      else if (reg_mode == 2'b01) r_q <= {r_q[W-2:0], reg_serial_in};
    end
  end
  assign reg_parallel_out = r_q;
  assign reg_serial_out   = (reg_mode == 2'b01) ? r_q[W-1] : r_q[0];

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  exp_t         sched_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rsp = '0;
  logic [W-1:0] shadow = '0;
  int           exp_cnt = 0;
  int           exp_cnt2 = 0;

  function automatic exp_t mk(input logic ready, input logic en, input logic load,
                              input logic si, input logic rv, input logic [1:0] mode,
                              input logic [W-1:0] pin, input logic [W-1:0] rsp);
    exp_t r;
    r.ready = ready; r.en = en; r.load = load; r.si = si; r.rv = rv;
    r.mode = mode; r.pin = pin; r.rsp = rsp;
    return r;
  endfunction

  function automatic void push_cmd(input logic [1:0] op, input logic [W-1:0] d);
    case (op)
      2'b00: begin
        sched_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, d, last_rsp));
        sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, d));
        exp_q.push_back(d);
        last_rsp = d;
        shadow   = d;
      end
      2'b01: begin
        sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, last_rsp));
        sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, shadow));
        exp_q.push_back(shadow);
        last_rsp = shadow;
      end
      default: begin
        for (int k = 0; k < W; k++)
          sched_q.push_back(mk(1'b0, 1'b1, 1'b0, (op == 2'b10) ? d[k] : d[W-1-k], 1'b0,
                               (op == 2'b10) ? 2'b00 : 2'b01, '0, last_rsp));
        sched_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, shadow));
        exp_q.push_back(shadow);
        last_rsp = shadow;
        shadow   = d;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t cur;
    if (started) begin
      if (sched_q.size() > 0) cur = sched_q.pop_front();
      else cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, last_rsp);
      check("cmd_ready", 32'(cmd_ready), 32'(cur.ready));
      check("rsp_valid", 32'(rsp_valid), 32'(cur.rv));
      check("rsp_data", 32'(rsp_data), 32'(cur.rsp));
      check("reg_enable", 32'(reg_enable), 32'(cur.en));
      check("reg_mode", 32'(reg_mode), 32'(cur.mode));
      check("reg_load", 32'(reg_load), 32'(cur.load));
      check("reg_serial_in", 32'(reg_serial_in), 32'(cur.si));
      check("reg_parallel_in", 32'(reg_parallel_in), 32'(cur.pin));
      check("fault_count", 32'(fault_count), 32'(exp_cnt));
      check("fault_irq", 32'(fault_irq), 32'(CNT_EN && exp_cnt >= THR));
      check("fault_count_w2", 32'(fault_count2), 32'(exp_cnt2));
      check("fault_irq_w2", 32'(fault_irq2), 32'(CNT_EN && exp_cnt2 >= 2));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_extra: got response %0h expected none at %0t", rsp_data, $time);
        end else begin
          check("rsp_scoreboard", 32'(rsp_data), 32'(exp_q.pop_front()));
        end
      end
      if (rst) begin
        exp_cnt  = 0;
        exp_cnt2 = 0;
        sched_q.delete();
        exp_q.delete();
        last_rsp = '0;
      end else begin
        if (CNT_EN) begin
          if (fault_clr) begin
            exp_cnt  = 0;
            exp_cnt2 = 0;
          end else if (reg_fault) begin
            if (!cur.en && exp_cnt < (1 << CW) - 1) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
          end
        end
        if (cur.ready && cmd_valid) push_cmd(cmd_op, cmd_data);
      end
    end
  end

  // ---------------- pin monitors for directed checks ----------------
  int           wr_cnt = 0, shr_cnt = 0, shl_cnt = 0, rv_cnt = 0;
  logic [W-1:0] si_log = '0;
  always @(negedge clk) begin
    if (reg_enable && reg_load && reg_mode == 2'b11) wr_cnt++;
    if (reg_enable && !reg_load && reg_mode == 2'b00) begin
      shr_cnt++;
      si_log = {reg_serial_in, si_log[W-1:1]};
    end
    if (reg_enable && reg_mode == 2'b01) shl_cnt++;
    if (rsp_valid) rv_cnt++;
  end

  // ---------------- random fault / clear noise ----------------
  always @(posedge clk) begin
    #1;
    if (noise_on) begin
      noise_fault = ($urandom_range(0, 5) == 0);
      noise_clr   = ($urandom_range(0, 40) == 0);
    end else begin
      noise_fault = 1'b0;
      noise_clr   = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!acc && n < 4 * W) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = W'($urandom);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d,
                         output logic [W-1:0] rsp, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    rsp = '0;
    send_cmd(op, d);
    while (!got && lat < 2 * W + 8) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        got = 1'b1;
        rsp = rsp_data;
      end
    end
    if (!got) check("rsp_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] rsp;
    int lat, base;

    tick(3);
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_reg_enable", 32'(reg_enable), 32'd0);
    check("rst_reg_pins", 32'({reg_mode, reg_load, reg_serial_in, reg_parallel_in}), 32'd0);
    check("rst_fault_count", 32'(fault_count), 32'd0);
    check("rst_fault_irq", 32'(fault_irq), 32'd0);

    base = wr_cnt;
    run_cmd(2'b00, 8'hA5, rsp, lat);
    check("write_a5_rsp", 32'(rsp), 32'h0000_00A5);
    check("write_latency", 32'(lat), 32'd2);
    check("write_strobes", 32'(wr_cnt - base), 32'd1);
    run_cmd(2'b01, 8'h00, rsp, lat);
    check("read_a5", 32'(rsp), 32'h0000_00A5);
    check("read_latency", 32'(lat), 32'd2);

    run_cmd(2'b00, 8'h3C, rsp, lat);
    base = shr_cnt;
    run_cmd(2'b10, 8'h81, rsp, lat);
    check("swap_r_rsp", 32'(rsp), 32'h0000_003C);
    check("swap_r_latency", 32'(lat), 32'd9);
    check("swap_r_cycles", 32'(shr_cnt - base), 32'd8);
    check("swap_r_serial_order", 32'(si_log), 32'h0000_0081);
    run_cmd(2'b01, 8'h00, rsp, lat);
    check("read_81", 32'(rsp), 32'h0000_0081);

    run_cmd(2'b00, 8'h0F, rsp, lat);
    base = shl_cnt;
    run_cmd(2'b11, 8'hF0, rsp, lat);
    check("swap_l_rsp", 32'(rsp), 32'h0000_000F);
    check("swap_l_mode01_cycles", 32'(shl_cnt - base), 32'd8);
    run_cmd(2'b01, 8'h00, rsp, lat);
    check("read_f0", 32'(rsp), 32'h0000_00F0);

    dir_clr = 1'b1;
    tick(1);
    dir_clr = 1'b0;
    check("count_cleared", 32'(fault_count), 32'd0);
    dir_fault = 1'b1;
    tick(1);
    dir_fault = 1'b0;
    check("count_one_fault", 32'(fault_count), 32'(CNT_EN ? 1 : 0));
    run_cmd(2'b01, 8'h00, rsp, lat);
    check("read_after_fault", 32'(rsp), 32'h0000_00F0);

    dir_clr = 1'b1;
    tick(1);
    dir_clr = 1'b0;
    dir_fault = 1'b1;
    tick(15);
    check("count_15", 32'(fault_count), 32'(CNT_EN ? 15 : 0));
    check("irq_below_thresh", 32'(fault_irq), 32'd0);
    tick(1);
    dir_fault = 1'b0;
    check("count_16", 32'(fault_count), 32'(CNT_EN ? 16 : 0));
    check("irq_at_thresh", 32'(fault_irq), 32'(CNT_EN));
    check("w2_saturated", 32'(fault_count2), 32'(CNT_EN ? 3 : 0));
    dir_fault = 1'b1;
    dir_clr = 1'b1;
    tick(1);
    dir_fault = 1'b0;
    dir_clr = 1'b0;
    check("clr_wins_count", 32'(fault_count), 32'd0);
    check("clr_wins_irq", 32'(fault_irq), 32'd0);

    send_cmd(2'b10, 8'h5A);
    tick(4);
    base = rv_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midshift_rst_ready", 32'(cmd_ready), 32'd1);
    check("midshift_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick(W + 2);
    check("midshift_no_response", 32'(rv_cnt - base), 32'd0);
    run_cmd(2'b00, 8'h66, rsp, lat);
    check("resync_write", 32'(rsp), 32'h0000_0066);

    noise_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 3));
      send_cmd(2'($urandom_range(0, 3)), W'($urandom));
    end
    noise_on = 1'b0;
    tick(2 * W + 4);
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
